con_stream_tx: RTL and testbench

CON_STREAM_TX -- requirements
Module: con_stream_tx

---
 rtl/con_stream_tx.sv | 162 ++++++++++++++++
 tb/tb_con_stream_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/con_stream_tx.sv
// con_stream_tx: streams kernel then feature-map words from a sync-read memory as 3-word beats.
// Ports:
//   clk, arst          clock, asynchronous active-high reset
//   start              one-cycle request to begin a transfer (ignored unless idle)
//   mem_re/addr/rdata  synchronous-read memory, data valid one cycle after mem_re
//   con_1..3           beat payload; con_valid/con_ready beat handshake
//   running            high in FETCH and SEND; driving_cons mirrors running
//   last_load_k        high while the final kernel beat is presented
//   done               one-cycle pulse after the final feature beat transfers
module con_stream_tx #(
   parameter int DATA_WIDTH         = 16,
   parameter int MEM_WIDTH          = 32,
   parameter int ADDR_WIDTH         = 20,
   parameter int FEATURE_MAP_WIDTH  = 64,
   parameter int FEATURE_MAP_HEIGHT = 64,
   parameter int INPUT_NB_CHANNELS  = 4,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int KERNEL_SIZE        = 3,
   parameter int K_BASE             = 0,
   parameter int F_BASE             = 4096
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  start,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [MEM_WIDTH-1:0]  mem_rdata,
   output logic [DATA_WIDTH-1:0] con_1,
   output logic [DATA_WIDTH-1:0] con_2,
   output logic [DATA_WIDTH-1:0] con_3,
   output logic                  con_valid,
   input  logic                  con_ready,
   output logic                  running,
   output logic                  driving_cons,
   output logic                  last_load_k,
   output logic                  done
);
   localparam int XB = (FEATURE_MAP_WIDTH + 2) / 3;
   localparam logic [ADDR_WIDTH-1:0] W_A  = ADDR_WIDTH'(FEATURE_MAP_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] H_A  = ADDR_WIDTH'(FEATURE_MAP_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] CI_A = ADDR_WIDTH'(INPUT_NB_CHANNELS);
   localparam logic [ADDR_WIDTH-1:0] K_A  = ADDR_WIDTH'(KERNEL_SIZE);
   localparam logic [ADDR_WIDTH-1:0] KB_A = ADDR_WIDTH'(K_BASE);
   localparam logic [ADDR_WIDTH-1:0] FB_A = ADDR_WIDTH'(F_BASE);

   typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

   state_t state_q, state_d;
   logic phase_q, phase_d;
   // c0 outer (cout / y), c1 middle (cin), c2 inner (ky / xb)
   logic [ADDR_WIDTH-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
   logic [1:0] fc_q, fc_d;
   logic [DATA_WIDTH-1:0] con1_q, con1_d, con2_q, con2_d, con3_q, con3_d;
   logic done_q, done_d;
   logic [ADDR_WIDTH-1:0] x_base, x_issue, x_cap, k_addr, f_addr;
   logic [1:0] cap_slot;
   logic [DATA_WIDTH-1:0] cap_data;
   logic issue_ok, cap_ok, last0, last1, last2;
   logic unused_rdata;

   // FETCH cycle fc issues slot fc and captures slot fc-1 from the previous read
   assign x_base   = ADDR_WIDTH'(3) * c2_q;
   assign x_issue  = x_base + ADDR_WIDTH'(fc_q);
   assign cap_slot = fc_q - 2'd1;
   assign x_cap    = x_base + ADDR_WIDTH'(cap_slot);
   assign issue_ok = !phase_q || x_issue < W_A;
   assign cap_ok   = !phase_q || x_cap < W_A;
   assign cap_data = cap_ok ? mem_rdata[DATA_WIDTH-1:0] : '0;
   assign unused_rdata = ^mem_rdata;

   assign k_addr   = KB_A + ((c0_q * CI_A + c1_q) * K_A + c2_q) * K_A + ADDR_WIDTH'(fc_q);
   assign f_addr   = FB_A + (c1_q * H_A + c0_q) * W_A + x_issue;
   assign mem_addr = phase_q ? f_addr : k_addr;
   assign mem_re   = state_q == FETCH && fc_q != 2'd3 && issue_ok;

   assign last2 = c2_q == (phase_q ? ADDR_WIDTH'(XB - 1) : K_A - 1'b1);
   assign last1 = c1_q == CI_A - 1'b1;
   assign last0 = c0_q == (phase_q ? H_A - 1'b1 : ADDR_WIDTH'(OUTPUT_NB_CHANNELS - 1));

   assign con_1        = con1_q;
   assign con_2        = con2_q;
   assign con_3        = con3_q;
   assign con_valid    = state_q == SEND;
   assign running      = state_q != IDLE;
   assign driving_cons = state_q != IDLE;
   assign last_load_k  = con_valid && !phase_q && last0 && last1 && last2;
   assign done         = done_q;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      fc_d    = fc_q;
      con1_d  = con1_q;
      con2_d  = con2_q;
      con3_d  = con3_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = FETCH;
            phase_d = 1'b0;
            c0_d    = '0;
            c1_d    = '0;
            c2_d    = '0;
            fc_d    = '0;
         end
         FETCH: begin
            fc_d = fc_q + 2'd1;
            if (fc_q == 2'd1) con1_d = cap_data;
            if (fc_q == 2'd2) con2_d = cap_data;
            if (fc_q == 2'd3) begin
               con3_d  = cap_data;
               state_d = SEND;
            end
         end
         SEND: if (con_ready) begin
            state_d = FETCH;
            fc_d    = '0;
            c2_d    = last2 ? '0 : c2_q + 1'b1;
            c1_d    = last2 ? (last1 ? '0 : c1_q + 1'b1) : c1_q;
            c0_d    = last2 && last1 ? (last0 ? '0 : c0_q + 1'b1) : c0_q;
            // all counters wrap together on the final beat of a phase
            if (last0 && last1 && last2) begin
               phase_d = 1'b1;
               if (phase_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         phase_q <= 1'b0;
         c0_q    <= '0;
         c1_q    <= '0;
         c2_q    <= '0;
         fc_q    <= '0;
         con1_q  <= '0;
         con2_q  <= '0;
         con3_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         fc_q    <= fc_d;
         con1_q  <= con1_d;
         con2_q  <= con2_d;
         con3_q  <= con3_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_con_stream_tx.sv
// tb_con_stream_tx: directed bench for con_stream_tx with a word-address-equals-data memory.
module tb_con_stream_tx;
   logic        clk = 1'b0;
   logic        arst, start, con_ready;
   logic        mem_re, con_valid, running, driving_cons, last_load_k, done;
   logic [19:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic [15:0] con_1, con_2, con_3;
   int total = 0, bad = 0;
   int mre_cnt = 0, xfer_cnt = 0, mre_prev = 0, xfer_prev = 0;

   con_stream_tx dut (
      .clk(clk), .arst(arst), .start(start),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .con_1(con_1), .con_2(con_2), .con_3(con_3),
      .con_valid(con_valid), .con_ready(con_ready),
      .running(running), .driving_cons(driving_cons),
      .last_load_k(last_load_k), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= {12'd0, mem_addr};
      if (mem_re) mre_cnt <= mre_cnt + 1;
      if (con_valid && con_ready) xfer_cnt <= xfer_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (con_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("valid_timeout", 32'(con_valid), 32'd1);
   endtask

   // n: global beat index, 0..383 kernel, 384..6015 feature
   task automatic check_beat(input int n);
      int w[3];
      int nv = 0;
      int m, y, ci, xb, x;
      if (n < 384) begin
         for (int s = 0; s < 3; s++) w[s] = 3 * n + s;
         nv = 3;
      end else begin
         m  = n - 384;
         y  = m / 88;
         ci = (m / 22) % 4;
         xb = m % 22;
         for (int s = 0; s < 3; s++) begin
            x = 3 * xb + s;
            if (x < 64) begin
               w[s] = (4096 + (ci * 64 + y) * 64 + x) & 32'hFFFF;
               nv++;
            end else w[s] = 0;
         end
      end
      wait_valid();
      chk($sformatf("con_1[%0d]", n), 32'(con_1), 32'(w[0]));
      chk($sformatf("con_2[%0d]", n), 32'(con_2), 32'(w[1]));
      chk($sformatf("con_3[%0d]", n), 32'(con_3), 32'(w[2]));
      chk($sformatf("last_load_k[%0d]", n), 32'(last_load_k), 32'(n == 383));
      chk($sformatf("mem_re_count[%0d]", n), 32'(mre_cnt - mre_prev), 32'(nv));
      mre_prev = mre_cnt;
      step();
   endtask

   initial begin
      arst = 1'b1;
      start = 1'b0;
      con_ready = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(con_valid), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_mem_re", 32'(mem_re), 0);
      chk("rst_con_1", 32'(con_1), 0);
      chk("rst_done", 32'(done), 0);
      arst = 1'b0;
      step();
      // first beat, observed cycle by cycle
      mre_prev = mre_cnt;
      xfer_prev = xfer_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("f0_running", 32'(running), 1);
      chk("f0_driving", 32'(driving_cons), 1);
      chk("f0_valid", 32'(con_valid), 0);
      chk("f0_mem_re", 32'(mem_re), 1);
      chk("f0_addr", 32'(mem_addr), 0);
      step();
      chk("f1_addr", 32'(mem_addr), 1);
      step();
      chk("f2_addr", 32'(mem_addr), 2);
      step();
      chk("f3_mem_re", 32'(mem_re), 0);
      chk("f3_valid", 32'(con_valid), 0);
      step();
      chk("s_valid", 32'(con_valid), 1);
      chk("s_con_1", 32'(con_1), 0);
      chk("s_con_2", 32'(con_2), 1);
      chk("s_con_3", 32'(con_3), 2);
      // backpressure with a start pulse while running
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         step();
      end
      start = 1'b0;
      chk("hold_valid", 32'(con_valid), 1);
      chk("hold_con_1", 32'(con_1), 0);
      chk("hold_con_2", 32'(con_2), 1);
      chk("hold_con_3", 32'(con_3), 2);
      chk("hold_xfer", 32'(xfer_cnt - xfer_prev), 0);
      con_ready = 1'b1;
      for (int n = 0; n < 6016; n++) check_beat(n);
      chk("end_done", 32'(done), 1);
      chk("end_running", 32'(running), 0);
      chk("end_valid", 32'(con_valid), 0);
      chk("end_xfers", 32'(xfer_cnt - xfer_prev), 6016);
      step();
      chk("end_done_low", 32'(done), 0);
      chk("end_running_low", 32'(running), 0);
      // second stream abandoned by reset at beat 100
      mre_prev = mre_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 0; n < 100; n++) check_beat(n);
      wait_valid();
      arst = 1'b1;
      #1;
      chk("ar_valid", 32'(con_valid), 0);
      chk("ar_con_1", 32'(con_1), 0);
      chk("ar_con_2", 32'(con_2), 0);
      chk("ar_con_3", 32'(con_3), 0);
      chk("ar_running", 32'(running), 0);
      chk("ar_driving", 32'(driving_cons), 0);
      chk("ar_mem_re", 32'(mem_re), 0);
      chk("ar_last_k", 32'(last_load_k), 0);
      chk("ar_done", 32'(done), 0);
      step();
      arst = 1'b0;
      step();
      step();
      step();
      chk("ar_wait_idle", 32'(running), 0);
      mre_prev = mre_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("re_addr0", 32'(mem_addr), 0);
      check_beat(0);
      check_beat(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
